// File: rtl/pipe_hazard_sb.sv
// pipe_hazard_sb -- ID-stage scoreboard hazard / forwarding unit.
//
// Tracks every in-flight register write by age (1..NSTAGE) and latency
// class (ALU, LOAD, MDU). From that state it produces RAW stalls, operand
// forwarding selects, an MDU structural stall, and a saturating stall counter.
//
// Ports:
//   clock, resetn          rising-edge clock, asynchronous active-low reset
//   id_valid               ID holds a real instruction
//   rs, rt, use_rs, use_rt source registers and their use flags
//   wreg, rd, lat_class    destination write enable, register, latency class
//   flush                  squash the ID instruction
//   hold                   global pipeline freeze
//   stall, issue           ID interlock / issue (combinational)
//   fwda, fwdb             operand source: 0 = register file, k = stage at age k
//   mdu_busy               MDU occupied (registered state)
//   perf_stall             saturating count of stall cycles (registered state)
module pipe_hazard_sb #(
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NSTAGE   = 3,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 2,
    parameter int FW       = $clog2(NSTAGE + 1)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          id_valid,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic          use_rs,
    input  logic          use_rt,
    input  logic          wreg,
    input  logic [AW-1:0] rd,
    input  logic [1:0]    lat_class,
    input  logic          flush,
    input  logic          hold,
    output logic          stall,
    output logic          issue,
    output logic [FW-1:0] fwda,
    output logic [FW-1:0] fwdb,
    output logic          mdu_busy,
    output logic [31:0]   perf_stall
);

    localparam int CW = $clog2(MDU_LAT + 1);

    // Age at which a result of the given class can be forwarded.
    function automatic logic [FW-1:0] rdy_age(input logic [1:0] cls);
        logic [FW-1:0] r;
        case (cls)
            2'd1:    r = FW'(LOAD_LAT + 1);
            2'd2:    r = FW'(MDU_LAT);
            default: r = FW'(1);
        endcase
        return r;
    endfunction

    logic [NREG-1:0] v_q, v_d;
    logic [FW-1:0]   age_q [NREG];
    logic [FW-1:0]   age_d [NREG];
    logic [1:0]      cls_q [NREG];
    logic [1:0]      cls_d [NREG];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     perf_q, perf_d;

    logic raw_rs_s, raw_rt_s, struct_s, mdu_issue_s, set_rd_s;

    // Hazard detection, issue and forwarding selects from the pre-edge state.
    always_comb begin
        raw_rs_s = use_rs && (rs != {AW{1'b0}}) && v_q[rs] &&
                   (age_q[rs] < rdy_age(cls_q[rs]));
        raw_rt_s = use_rt && (rt != {AW{1'b0}}) && v_q[rt] &&
                   (age_q[rt] < rdy_age(cls_q[rt]));
        mdu_busy = (cnt_q != {CW{1'b0}});
        struct_s = wreg && (lat_class == 2'd2) && mdu_busy;
        stall    = id_valid && (raw_rs_s || raw_rt_s || struct_s);
        issue    = id_valid && !stall && !flush && !hold;
        if (use_rs && (rs != {AW{1'b0}}) && v_q[rs]) begin
            fwda = age_q[rs];
        end else begin
            fwda = {FW{1'b0}};
        end
        if (use_rt && (rt != {AW{1'b0}}) && v_q[rt]) begin
            fwdb = age_q[rt];
        end else begin
            fwdb = {FW{1'b0}};
        end
        // The MDU is occupied by any issued MDU op, even one writing r0.
        mdu_issue_s = issue && wreg && (lat_class == 2'd2);
        set_rd_s    = issue && wreg && (rd != {AW{1'b0}});
        perf_stall  = perf_q;
    end

    // Next-state: age entries, retire at NSTAGE, allocate the issuing writer.
    always_comb begin
        v_d    = v_q;
        age_d  = age_q;
        cls_d  = cls_q;
        cnt_d  = cnt_q;
        perf_d = perf_q;
        if (!hold) begin
            for (int r = 1; r < NREG; r++) begin
                if (v_q[r] && (age_q[r] == FW'(NSTAGE))) begin
                    v_d[r] = 1'b0;
                end else if (v_q[r]) begin
                    age_d[r] = age_q[r] + FW'(1);
                end else begin
                    v_d[r] = v_q[r];
                end
            end
            // A new writer replaces any older entry for the same register.
            if (set_rd_s) begin
                v_d[rd]   = 1'b1;
                age_d[rd] = FW'(1);
                cls_d[rd] = lat_class;
            end else begin
                v_d[0] = 1'b0;
            end
            if (mdu_issue_s) begin
                cnt_d = CW'(MDU_LAT);
            end else if (cnt_q != {CW{1'b0}}) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
            if (stall && (perf_q != 32'hFFFF_FFFF)) begin
                perf_d = perf_q + 32'd1;
            end else begin
                perf_d = perf_q;
            end
        end else begin
            v_d = v_q;
        end
        v_d[0] = 1'b0;
    end

    // State registers; reset discards every pending entry immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v_q    <= {NREG{1'b0}};
            cnt_q  <= {CW{1'b0}};
            perf_q <= 32'd0;
            for (int r = 0; r < NREG; r++) begin
                age_q[r] <= {FW{1'b0}};
                cls_q[r] <= 2'd0;
            end
        end else begin
            v_q    <= v_d;
            cnt_q  <= cnt_d;
            perf_q <= perf_d;
            for (int r = 0; r < NREG; r++) begin
                age_q[r] <= age_d[r];
                cls_q[r] <= cls_d[r];
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_sb.sv
module tb_pipe_hazard_sb;

    localparam int NREG = 32, AW = 5, NSTAGE = 3, LOAD_LAT = 1, MDU_LAT = 2, FW = 2;

    logic clock = 1'b0;
    logic resetn;
    logic id_valid, use_rs, use_rt, wreg, flush, hold;
    logic [AW-1:0] rs, rt, rd;
    logic [1:0] lat_class;
    logic stall, issue, mdu_busy;
    logic [FW-1:0] fwda, fwdb;
    logic [31:0] perf_stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pipe_hazard_sb #(.NREG(NREG), .AW(AW), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT),
                     .MDU_LAT(MDU_LAT), .FW(FW)) dut (
        .clock(clock), .resetn(resetn), .id_valid(id_valid), .rs(rs), .rt(rt),
        .use_rs(use_rs), .use_rt(use_rt), .wreg(wreg), .rd(rd), .lat_class(lat_class),
        .flush(flush), .hold(hold), .stall(stall), .issue(issue), .fwda(fwda),
        .fwdb(fwdb), .mdu_busy(mdu_busy), .perf_stall(perf_stall));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_st, input logic e_is,
                           input int e_fa, input int e_fb, input logic e_bz, input int e_pf);
        chk({tag, " stall"}, 32'(stall), 32'(e_st));
        chk({tag, " issue"}, 32'(issue), 32'(e_is));
        chk({tag, " fwda"}, 32'(fwda), 32'(e_fa));
        chk({tag, " fwdb"}, 32'(fwdb), 32'(e_fb));
        chk({tag, " mdu_busy"}, 32'(mdu_busy), 32'(e_bz));
        chk({tag, " perf_stall"}, perf_stall, 32'(e_pf));
    endtask

    task automatic drive(input logic v, input int s, input int t, input logic us, input logic ut,
                         input logic w, input int d, input int c, input logic fl, input logic hd);
        id_valid = v; rs = AW'(s); rt = AW'(t); use_rs = us; use_rt = ut;
        wreg = w; rd = AW'(d); lat_class = 2'(c); flush = fl; hold = hd;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic v; int rs; int rt; logic urs; logic urt; logic wr; int rd; int cls;
        logic fl; logic hd;
        logic e_st; logic e_is; int e_fa; int e_fb; logic e_bz; int e_pf;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(logic v, int s, int t, logic us, logic ut, logic w, int d, int c,
                                logic fl, logic hd, logic est, logic eis, int efa, int efb,
                                logic ebz, int epf);
        vec_t x;
        x.v = v; x.rs = s; x.rt = t; x.urs = us; x.urt = ut; x.wr = w; x.rd = d; x.cls = c;
        x.fl = fl; x.hd = hd; x.e_st = est; x.e_is = eis; x.e_fa = efa; x.e_fb = efb;
        x.e_bz = ebz; x.e_pf = epf;
        return x;
    endfunction

    // ---------------- reference model ----------------
    // In-flight writes are timestamps on a count of non-hold edges; age is elapsed edges + 1.
    typedef struct { int rd; int cls; int ts; } wr_t;
    wr_t q[$];
    int  n_tick;
    int  mdu_ts;
    bit  mdu_on;
    int  perf_m;

    task automatic model_reset();
        q.delete();
        n_tick = 0;
        mdu_on = 1'b0;
        mdu_ts = 0;
        perf_m = 0;
    endtask

    task automatic lookup(input int x, output bit f, output int age, output int cls);
        int best;
        f = 1'b0; age = 0; cls = 0; best = -1;
        foreach (q[i]) begin
            if (q[i].rd == x && q[i].ts > best) begin
                best = q[i].ts; f = 1'b1; age = n_tick - q[i].ts + 1; cls = q[i].cls;
            end
        end
    endtask

    function automatic int rdy(int cls);
        if (cls == 1) return LOAD_LAT + 1;
        if (cls == 2) return MDU_LAT;
        return 1;
    endfunction

    task automatic model_eval(output logic e_st, output logic e_is, output int e_fa,
                              output int e_fb, output logic e_bz);
        bit fs, ft;
        int as_, cs, at, ct;
        logic raw_s, raw_t;
        lookup(int'(rs), fs, as_, cs);
        lookup(int'(rt), ft, at, ct);
        raw_s = use_rs && rs != 0 && fs && as_ < rdy(cs);
        raw_t = use_rt && rt != 0 && ft && at < rdy(ct);
        e_bz  = mdu_on && (n_tick - mdu_ts) < MDU_LAT;
        e_st  = id_valid && (raw_s || raw_t || (wreg && lat_class == 2 && e_bz));
        e_is  = id_valid && !e_st && !flush && !hold;
        e_fa  = (use_rs && rs != 0 && fs) ? as_ : 0;
        e_fb  = (use_rt && rt != 0 && ft) ? at : 0;
    endtask

    task automatic model_step(input logic e_st, input logic e_is);
        wr_t w;
        if (hold) return;
        n_tick++;
        if (e_is && wreg && rd != 0) begin
            w.rd = int'(rd); w.cls = int'(lat_class); w.ts = n_tick;
            q.push_back(w);
        end
        if (e_is && wreg && lat_class == 2) begin
            mdu_on = 1'b1; mdu_ts = n_tick;
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (n_tick - q[i].ts + 1 > NSTAGE) q.delete(i);
        end
        if (id_valid && e_st && perf_m != 32'hFFFF_FFFF) perf_m++;
    endtask

    initial begin
        logic e_st, e_is, e_bz;
        int e_fa, e_fb;

        //          v rs rt us ut w rd c fl hd | st is fa fb bz pf
        tbl[0]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 3, 5, 1, 1, 1, 4, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[2]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        tbl[3]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        tbl[4]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(1, 2, 2, 1, 1, 1, 6, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        tbl[7]  = mk(1, 2, 2, 1, 1, 1, 6, 0, 0, 0, 0, 1, 2, 2, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 0, 1, 7, 2, 0, 0, 0, 1, 0, 0, 0, 1);
        tbl[9]  = mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1);
        tbl[10] = mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 2);
        tbl[11] = mk(1, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0, 1, 0, 0, 0, 2);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        tbl[13] = mk(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, 1, 0, 0, 0, 1, 2);
        tbl[14] = mk(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 1, 0, 0, 0, 3);
        tbl[15] = mk(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 1, 0, 0, 1, 3);
        tbl[16] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 3);
        tbl[17] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 3);
        tbl[18] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 3);
        tbl[19] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 3);
        tbl[20] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 4);
        tbl[21] = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4);
        tbl[22] = mk(1, 0, 0, 1, 0, 1, 11, 1, 0, 0, 0, 1, 0, 0, 0, 4);
        tbl[23] = mk(1, 11, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4);
        tbl[24] = mk(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 1, 0, 0, 0, 4);
        tbl[25] = mk(1, 12, 0, 1, 0, 1, 13, 0, 1, 0, 1, 0, 1, 0, 0, 4);
        tbl[26] = mk(1, 13, 12, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 5);
        tbl[27] = mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 1, 0, 0, 0, 5);
        tbl[28] = mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 5);
        tbl[29] = mk(1, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5);

        // Reset state: issue still follows id_valid & ~flush & ~hold.
        resetn = 1'b0;
        drive(1, 3, 4, 1, 1, 1, 5, 1, 0, 0);
        repeat (2) @(negedge clock);
        #1;
        chk_all("reset", 0, 1, 0, 0, 0, 0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].wr,
                  tbl[i].rd, tbl[i].cls, tbl[i].fl, tbl[i].hd);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].e_st, tbl[i].e_is, tbl[i].e_fa,
                    tbl[i].e_fb, tbl[i].e_bz, tbl[i].e_pf);
            @(negedge clock);
        end

        // Mid-sequence reset: MDU r15, lw r14, stalled reader, then resetn low.
        drive(1, 0, 0, 0, 0, 1, 15, 2, 0, 0);
        @(negedge clock);
        drive(1, 0, 0, 0, 0, 1, 14, 1, 0, 0);
        @(negedge clock);
        drive(1, 14, 15, 1, 1, 0, 0, 0, 0, 0);
        #1;
        chk_all("pre_rst", 1, 0, 1, 2, 1, 5);
        #2;
        resetn = 1'b0;
        #1;
        chk_all("mid_rst", 0, 1, 0, 0, 0, 0);
        @(negedge clock);
        resetn = 1'b1;

        // Randomized run against the reference model.
        resetn = 1'b0;
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clock);
            resetn = 1'b1;
            drive($urandom_range(99) < 85, $urandom_range(7), $urandom_range(7),
                  $urandom_range(1), $urandom_range(1), $urandom_range(99) < 70,
                  $urandom_range(7), $urandom_range(3), $urandom_range(99) < 10,
                  $urandom_range(99) < 15);
            if ($urandom_range(99) == 0) begin
                resetn = 1'b0;
                model_reset();
            end
            #1;
            model_eval(e_st, e_is, e_fa, e_fb, e_bz);
            chk_all($sformatf("rnd%0d", k), e_st, e_is, e_fa, e_fb, e_bz, perf_m);
            @(posedge clock);
            if (resetn) model_step(e_st, e_is);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
